counter_mod: RTL

Parametrised modulo up/down counter with a programmable prescaler, synchronous load/clear and wrap or saturate behaviour at a runtime-programmable limit. It is the general-purpose successor to the free-running counter. It is intended as the timebase and event counter for blinkers, display multiplexers, PWM periods and timeouts throughout the FPGA designs. All outputs are registered.

---
 rtl/counter_mod.sv | 95 +++++++++
 1 files changed

// File: rtl/counter_mod.sv
// Modulo up/down counter with prescaler, sync clear/load, wrap or saturate at a runtime limit.
// Latency: one edge from step decision to out_ctr/out_tick/out_wrap; no backpressure, in_enable freezes state.
module counter_mod #(
   parameter int num_ctrbits      = 16,
   parameter int num_prescalebits = 8,
   parameter bit saturate         = 1'b0
) (
   input  logic                        in_clk,
   input  logic                        in_rst,
   input  logic                        in_enable,
   input  logic                        in_clear,
   input  logic                        in_load,
   input  logic [num_ctrbits-1:0]      in_load_val,
   input  logic                        in_down,
   input  logic [num_prescalebits-1:0] in_prescale,
   input  logic [num_ctrbits-1:0]      in_max,
   output logic [num_ctrbits-1:0]      out_ctr,
   output logic                        out_tick,
   output logic                        out_wrap
);

   logic [num_ctrbits-1:0]      ctr;
   logic [num_prescalebits-1:0] pre;
   logic                        tick;
   logic                        wrap;

   logic [num_ctrbits-1:0]      step_val;
   logic                        step_wrap;
   logic                        pre_match;

   assign pre_match = (pre == in_prescale);

   // Limit checks come first so the +1/-1 paths can never overflow.
   always_comb begin
      step_val  = ctr;
      step_wrap = 1'b0;
      if (!in_down) begin
         if (ctr >= in_max) begin
            step_val  = saturate ? in_max : '0;
            step_wrap = 1'b1;
         end else begin
            step_val  = ctr + 1'b1;
         end
      end else begin
         if (ctr == '0) begin
            step_val  = saturate ? '0 : in_max;
            step_wrap = 1'b1;
         end else if (ctr > in_max) begin
            step_val  = in_max;
            step_wrap = 1'b1;
         end else begin
            step_val  = ctr - 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         ctr  <= '0;
         pre  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (in_clear) begin
         ctr  <= '0;
         pre  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (in_load) begin
         ctr  <= in_load_val;
         pre  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (in_enable) begin
         if (pre_match) begin
            pre  <= '0;
            ctr  <= step_val;
            tick <= 1'b1;
            wrap <= step_wrap;
         end else begin
            // A prescale lowered below pre lets pre run on and wrap before matching.
            pre  <= pre + 1'b1;
            tick <= 1'b0;
            wrap <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end
   end

   assign out_ctr  = ctr;
   assign out_tick = tick;
   assign out_wrap = wrap;

endmodule
